// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single 1-bit full-subtractor stage with a registered borrow.
//
// Handshake (valid/ready style): start is the request and is accepted only
// on an edge where the block is idle (busy=0). While busy=1 the request and
// the operand inputs are ignored. done is a one-cycle pulse during which
// diff/bout/ovf are valid. Those three outputs then hold until the next
// accepted start.
module serial_subtractor4 #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int IW = $clog2(width);
  localparam logic [IW-1:0] LAST_IDX = IW'(width - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [width-1:0] a_q;
  logic [width-1:0] b_q;
  logic [width-1:0] diff_q;
  logic [IW-1:0]    idx_q;
  logic             br_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             busy_q;
  logic             done_q;
  logic             bout_q;
  logic             ovf_q;

  logic             d_bit_d;
  logic             br_d;
  logic             ovf_d;

  // One full-subtractor stage on the current LSBs of the operand shifters.
  // The overflow term is only consumed on the last bit, where d_bit_d is
  // the sign bit of the result.
  always_comb begin
    d_bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    ovf_d   = (a_msb_q != b_msb_q) & (d_bit_d != a_msb_q);
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      idx_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            idx_q   <= '0;
            // Sign bits are kept aside because the shifters lose them.
            a_msb_q <= a[width-1];
            b_msb_q <= b[width-1];
            busy_q  <= 1'b1;
            state_q <= SUB;
          end
        end
        SUB: begin
          a_q    <= {1'b0, a_q[width-1:1]};
          b_q    <= {1'b0, b_q[width-1:1]};
          diff_q <= {d_bit_d, diff_q[width-1:1]};
          br_q   <= br_d;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            bout_q  <= br_d;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor4.sv
// Testbench for serial_subtractor4 (width 4): directed and random
// operations compared with an arithmetic reference model via a queue.
module tb_serial_subtractor4;

  localparam int W = 4;
  localparam int TIMEOUT = 30;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  always #5 clk = ~clk;

  serial_subtractor4 #(.width(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];  // {ovf, bout, diff}
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [W+1:0] model(input int av, input int bv, input int bi);
    int r;
    int sa;
    int sb;
    int sr;
    logic [W-1:0] d;
    logic bo;
    logic ov;
    r  = av - bv - bi;
    d  = W'(r & ((1 << W) - 1));
    bo = (r < 0);
    sa = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
    sb = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
    sr = sa - sb - bi;
    ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return {ov, bo, d};
  endfunction

  // ---------------- driver tasks ----------------
  // Counts falling edges until done is seen; n = -1 on timeout.
  task automatic wait_done(output int n);
    n = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_in_op", busy, 1'b1);
      if (done) begin
        n = k;
        return;
      end
    end
    n = -1;
  endtask

  task automatic check_result(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_diff"}, diff, e[W-1:0]);
    chk({tag, "_bout"}, bout, e[W]);
    chk({tag, "_ovf"},  ovf,  e[W+1]);
  endtask

  // One full operation: drive, check latency, result, and post-done hold.
  task automatic run_op(input string tag, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic bi);
    int n;
    logic [W+1:0] e;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    e = model(int'(av), int'(bv), int'(bi));
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    a = W'($urandom_range(0, (1 << W) - 1));  // ignored while busy
    wait_done(n);
    chk({tag, "_latency"}, n, W + 1);
    check_result(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
    chk({tag, "_hold"}, diff, e[W-1:0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int dcount;
    int ph;
    logic [W-1:0] a2;
    logic [W-1:0] b2;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 1'b0);
    chk("rst_ovf",  ovf,  1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op("d9m3", 4'd9, 4'd3, 1'b0);
    run_op("d3m9", 4'd3, 4'd9, 1'b0);
    run_op("d0m0b", 4'd0, 4'd0, 1'b1);
    run_op("ovf8m1", 4'd8, 4'd1, 1'b0);
    run_op("ovf7m15", 4'd7, 4'd15, 1'b0);

    // Asynchronous reset pulse mid-cycle while outputs are non-zero.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_diff", diff, 0);
    chk("arst_bout", bout, 1'b0);
    chk("arst_ovf",  ovf,  1'b0);
    chk("arst_busy", busy, 1'b0);
    #1 rst = 1'b0;

    // Start held high; operand changes during busy must be ignored.
    @(negedge clk);
    a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
    a2 = 4'd4; b2 = 4'd11;
    exp_q.push_back(model(5, 2, 0));
    exp_q.push_back(model(int'(a2), int'(b2), 1));
    @(posedge clk);
    #1 a = W'($urandom); b = W'($urandom); bin = 1'b1;
    wait_done(n);
    chk("held1_latency", n, W + 1);
    check_result("held1");
    a = a2; b = b2; bin = 1'b1;  // sampled at the first IDLE edge after DONE
    n = -1;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (done) begin
        n = k;
        break;
      end
      if (k >= 2) begin
        a = W'($urandom); b = W'($urandom); bin = 1'(($urandom));
      end
    end
    start = 1'b0;
    chk("held_spacing", n, W + 2);
    check_result("held2");

    // Reset after two bits processed: operation abandoned, no done.
    @(negedge clk);
    @(negedge clk);
    a = 4'd6; b = 4'd1; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("sub_rst_busy", busy, 1'b0);
    chk("sub_rst_diff", diff, 0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("sub_rst_no_done", dcount, 0);
    run_op("d15m15", 4'd15, 4'd15, 1'b0);

    // Random operations.
    for (int k = 0; k < 12; k++) begin
      ph = k;
      run_op($sformatf("rnd%0d", ph), W'($urandom_range(0, (1 << W) - 1)),
             W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)));
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
